// File: rtl/bresenham_line_engine.sv
// bresenham_line_engine: queued all-octant Bresenham rasteriser emitting one pixel per valid/ready handshake.
module bresenham_line_engine #(
    parameter int COORD_W    = 10,
    parameter int COLOR_W    = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               abort,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_last,
    output logic               busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = COORD_W + 2;
    localparam int EW = COORD_W + 3;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COLOR_W-1:0] color;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    cmd_t                mem_q [FIFO_DEPTH];
    cmd_t                head;
    logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
    logic                empty, full, push, pop, hs, step, mx, my;
    state_t              state_q, state_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d, adx, ady;
    logic [COLOR_W-1:0]  color_q, color_d;
    logic signed [SW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                sxn_q, sxn_d, syn_q, syn_d;
    logic signed [EW-1:0] e2;

    assign head      = mem_q[rd_q[AW-1:0]];
    assign empty     = wr_q == rd_q;
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign cmd_ready = !full && !abort;
    assign push      = cmd_valid && cmd_ready;
    assign hs        = pix_valid && pix_ready;
    assign step      = hs && !pix_last;
    assign pop       = state_d == SETUP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sxn_q   <= 1'b0;
            syn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sxn_q   <= sxn_d;
            syn_q   <= syn_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && rst)
            mem_q[wr_q[AW-1:0]] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
    end

    always_comb begin
        state_d = abort               ? IDLE :
                  state_q == IDLE     ? (empty ? IDLE : SETUP) :
                  state_q == SETUP    ? DRAW :
                  (hs && pix_last)    ? (empty ? IDLE : SETUP) : DRAW;
    end

    always_comb begin
        pix_valid = state_q == DRAW;
        pix_last  = pix_valid && x_q == x1_q && y_q == y1_q;
        busy      = state_q != IDLE || !empty;
        pix_x     = x_q;
        pix_y     = y_q;
        pix_color = color_q;
    end

    always_comb begin
        wr_d = abort ? '0 : wr_q + (AW+1)'(push);
        rd_d = abort ? '0 : rd_q + (AW+1)'(pop);
    end

    // Both axis decisions use the pre-update error so diagonal steps happen in one cycle.
    always_comb begin
        adx     = head.x1 >= head.x0 ? head.x1 - head.x0 : head.x0 - head.x1;
        ady     = head.y1 >= head.y0 ? head.y1 - head.y0 : head.y0 - head.y1;
        e2      = $signed({err_q, 1'b0});
        mx      = e2 >= EW'(dy_q);
        my      = e2 <= EW'(dx_q);
        x_d     = x_q;
        y_d     = y_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sxn_d   = sxn_q;
        syn_d   = syn_q;
        if (pop) begin
            x_d     = head.x0;
            y_d     = head.y0;
            x1_d    = head.x1;
            y1_d    = head.y1;
            color_d = head.color;
            sxn_d   = head.x1 < head.x0;
            syn_d   = head.y1 < head.y0;
            dx_d    = $signed(SW'(adx));
            dy_d    = -$signed(SW'(ady));
            err_d   = $signed(SW'(adx)) - $signed(SW'(ady));
        end else if (step) begin
            x_d   = mx ? x_q + (sxn_q ? {COORD_W{1'b1}} : COORD_W'(1)) : x_q;
            y_d   = my ? y_q + (syn_q ? {COORD_W{1'b1}} : COORD_W'(1)) : y_q;
            err_d = err_q + (mx ? dy_q : SW'(0)) + (my ? dx_q : SW'(0));
        end
    end
endmodule

// File: tb/tb_bresenham_line_engine.sv
// tb_bresenham_line_engine: randomized scoreboard bench comparing emitted pixels against an integer line model.
module tb_bresenham_line_engine;
    localparam int W  = 10;
    localparam int CW = 12;

    logic          clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, abort = 1'b0, pix_ready = 1'b0;
    logic [W-1:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [CW-1:0] cmd_color = '0;
    logic          cmd_ready, pix_valid, pix_last, busy;
    logic [W-1:0]  pix_x, pix_y;
    logic [CW-1:0] pix_color;

    bresenham_line_engine #(.COORD_W(W), .COLOR_W(CW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .abort(abort), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_last(pix_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int c; int last;} pix_t;
    pix_t exp_q[$];
    int n_chk = 0, n_pass = 0, n_hs = 0, ready_mode = 0;

    task automatic check(input string tag, input longint got, input longint want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    // Reference line: textbook integer Bresenham, one entry per expected pixel.
    task automatic model(input int x0, input int y0, input int x1, input int y1, input int c);
        int dx = x1 >= x0 ? x1 - x0 : x0 - x1;
        int dy = -(y1 >= y0 ? y1 - y0 : y0 - y1);
        int sx = x1 >= x0 ? 1 : -1;
        int sy = y1 >= y0 ? 1 : -1;
        int err = dx + dy;
        int x = x0, y = y0, e2;
        pix_t p;
        for (int k = 0; k < 4096; k++) begin
            p.x = x; p.y = y; p.c = c; p.last = int'(x == x1 && y == y1);
            exp_q.push_back(p);
            if (p.last != 0) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic send(input int x0, input int y0, input int x1, input int y1, input int c, output bit acc);
        cmd_valid = 1'b1;
        cmd_x0 = W'(x0); cmd_y0 = W'(y0); cmd_x1 = W'(x1); cmd_y1 = W'(y1); cmd_color = CW'(c);
        @(negedge clk);
        acc = cmd_ready;
        if (acc) model(x0, y0, x1, y1, c);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_retry(input int x0, input int y0, input int x1, input int y1, input int c);
        bit acc = 1'b0;
        for (int i = 0; i < 3000 && !acc; i++) send(x0, y0, x1, y1, c, acc);
        check("retry_accept", acc, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30000 && (busy || exp_q.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_busy"}, busy, 0);
        check({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic find_x(input int want);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (pix_valid && int'(pix_x) == want) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("find_pixel", found, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            pix_ready = ready_mode == 2 ? ($urandom % 3 != 0) : (ready_mode == 1);
        end
    end

    // Scoreboard plus stall-stability and inter-line bubble checks.
    initial begin
        logic          stall = 1'b0, lasths = 1'b0, hl = 1'b0;
        logic [W-1:0]  hx = '0, hy = '0;
        logic [CW-1:0] hc = '0;
        pix_t p;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (lasths) check("bubble", pix_valid, 0);
                if (stall && pix_valid) begin
                    check("hold_x", pix_x, hx);
                    check("hold_y", pix_y, hy);
                    check("hold_color", pix_color, hc);
                    check("hold_last", pix_last, hl);
                end
                if (pix_valid && pix_ready) begin
                    n_hs++;
                    if (exp_q.size() == 0) check("extra_pixel", 1, 0);
                    else begin
                        p = exp_q.pop_front();
                        check("pix_x", pix_x, p.x);
                        check("pix_y", pix_y, p.y);
                        check("pix_color", pix_color, p.c);
                        check("pix_last", pix_last, p.last);
                    end
                end
            end
            stall  = rst && pix_valid && !pix_ready;
            lasths = rst && pix_valid && pix_ready && pix_last;
            hx = pix_x; hy = pix_y; hc = pix_color; hl = pix_last;
        end
    end

    initial begin
        bit acc;
        int n, t;
        #2;
        check("rst_valid", pix_valid, 0);
        check("rst_x", pix_x, 0);
        check("rst_y", pix_y, 0);
        check("rst_color", pix_color, 0);
        check("rst_last", pix_last, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        ready_mode = 1;
        check("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        send(0, 0, 4, 0, 'hF00, acc);
        check("single_accept", acc, 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pix_valid) break;
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        check("latency", n, 2);
        wait_idle("single");

        send_retry(10, 10, 7, 3, 'h0A5);
        wait_idle("steep");

        n = n_hs;
        send_retry(5, 5, 5, 5, 'h123);
        wait_idle("degen");
        check("degen_count", n_hs - n, 1);

        n = n_hs;
        send_retry(1023, 0, 0, 1023, 'hFFF);
        wait_idle("anti_diag");
        check("anti_diag_count", n_hs - n, 1024);

        ready_mode = 2;
        send_retry(0, 0, 6, 3, 'h0F0);
        wait_idle("backpressure");

        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 4095), acc);
            n += int'(acc);
        end
        check("fifo_accepted", n, 5);
        check("fifo_full_ready", acc, 0);
        check("fifo_busy", busy, 1);
        ready_mode = 1;
        wait_idle("fifo");

        repeat (2) @(posedge clk);
        #1;
        n = n_hs;
        send(0, 0, 9, 0, 'h00F, acc);
        send(3, 3, 8, 8, 'h111, acc);
        send(1, 9, 6, 2, 'h222, acc);
        find_x(2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        check("abort_valid", pix_valid, 0);
        check("abort_last", pix_last, 0);
        check("abort_busy", busy, 0);
        check("abort_count", n_hs - n, 3);
        repeat (5) @(posedge clk);
        #1;
        check("abort_quiet", pix_valid || busy, 0);

        send_retry(0, 0, 9, 9, 'h333);
        find_x(3);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", pix_valid, 0);
        check("arst_x", pix_x, 0);
        check("arst_y", pix_y, 0);
        check("arst_color", pix_color, 0);
        check("arst_last", pix_last, 0);
        check("arst_busy", busy, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        send_retry(2, 3, 8, 1, 'h444);
        wait_idle("post_reset");

        ready_mode = 2;
        for (int i = 0; i < 12; i++) begin
            t = (i % 3 == 0) ? 1023 : 20;
            send_retry($urandom_range(0, t), $urandom_range(0, t), $urandom_range(0, t),
                       $urandom_range(0, t), $urandom_range(0, 4095));
        end
        wait_idle("random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
